// File: rtl/enable_count_source_if.sv
// my_bus: clocked bus carrying a count-enable from the sink and a data lane from the source.
interface my_bus #(
  parameter int WIDTH = 8
) (
  input logic clk
);

  logic             enable;
  logic [WIDTH-1:0] data;

  modport dut    (input clk, input enable, output data);
  modport tb     (input clk, output enable, input data);
  modport master (input clk, input enable, output data);
  modport slave  (input clk, output enable, input data);

endinterface

// File: rtl/enable_count_source.sv
// Bus source: WIDTH-bit up-counter that counts while enable is high and clears while it is low.
module enable_count_source #(
  parameter int WIDTH = 8
) (
  my_bus.dut  bus,
  input logic rst_n
);

  logic [WIDTH-1:0] count;

  // Enable low clears rather than holds, so a later enable restarts from zero.
  always_ff @(posedge bus.clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (bus.enable) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= '0;
    end
  end

  assign bus.data = count;

endmodule

// File: tb/tb_enable_count_source.sv
// Bench for enable_count_source at WIDTH 8 and 4, sharing one clock, reset and enable stimulus.
module tb_enable_count_source;

  logic clk;
  logic rst_n;
  logic en;

  int tests;
  int fails;

  // Model: data equals the number of consecutive edges seen with rst_n and enable both high,
  // reduced modulo 2^WIDTH. Invalid until the first reset edge.
  int run;
  bit model_valid;

  my_bus #(.WIDTH(8)) bus8 (.clk(clk));
  my_bus #(.WIDTH(4)) bus4 (.clk(clk));

  assign bus8.enable = en;
  assign bus4.enable = en;

  enable_count_source #(.WIDTH(8)) dut8 (
    .bus   (bus8.dut),
    .rst_n (rst_n)
  );

  enable_count_source #(.WIDTH(4)) dut4 (
    .bus   (bus4.dut),
    .rst_n (rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      run         <= 0;
      model_valid <= 1'b1;
    end else if (en) begin
      run <= run + 1;
    end else begin
      run <= 0;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      tests++;
      if (bus8.data !== 8'(run % 256)) begin
        fails++;
        $display("FAIL model_w8 t=%0t actual=%0d required=%0d", $time, bus8.data, run % 256);
      end
      tests++;
      if (bus4.data !== 4'(run % 16)) begin
        fails++;
        $display("FAIL model_w4 t=%0t actual=%0d required=%0d", $time, bus4.data, run % 16);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input int required);
    tests++;
    if (bus8.data !== 8'(required)) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, bus8.data, required);
    end
  endtask

  task automatic check4(input string name, input int required);
    tests++;
    if (bus4.data !== 4'(required)) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, bus4.data, required);
    end
  endtask

  // Enable pulse: enable seen at successive edges and the data required after each.
  logic [7:0] pulse_en;
  int         pulse_exp [8];

  initial begin
    tests       = 0;
    fails       = 0;
    run         = 0;
    model_valid = 1'b0;
    pulse_en    = 8'b1111_0110;
    pulse_exp   = '{0, 1, 2, 0, 1, 2, 3, 4};

    en    = 1'b1;
    rst_n = 1'b0;

    // Reset held two edges with enable high
    tick(); check8("reset_edge1", 0); check4("reset_edge1_w4", 0);
    tick(); check8("reset_edge2", 0);
    rst_n = 1'b1;
    tick(); check8("release_1", 1);
    tick(); check8("release_2", 2);
    tick(); check8("release_3", 3);

    en = 1'b0;
    tick(); check8("pre_pulse_clear", 0);

    for (int i = 0; i < 8; i++) begin
      en = pulse_en[i];
      tick();
      check8($sformatf("pulse_%0d", i), pulse_exp[i]);
    end

    // Clear after counting to 5
    en = 1'b1;
    tick(); check8("count_to_5", 5);
    en = 1'b0;
    tick(); check8("clear", 0);
    en = 1'b1;
    tick(); check8("clear_restart", 1);

    // Reset priority after counting to 7
    for (int i = 0; i < 6; i++) tick();
    check8("count_to_7", 7);
    rst_n = 1'b0;
    tick(); check8("reset_priority", 0);
    rst_n = 1'b1;
    tick(); check8("reset_priority_restart", 1);

    // Wrap for both widths from zero
    en = 1'b0;
    tick(); check8("wrap_start", 0); check4("wrap_start_w4", 0);
    en = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      tick();
      if (i == 15)  check4("w4_at_15", 15);
      if (i == 16)  check4("w4_wrap", 0);
      if (i == 17)  check4("w4_end", 1);
      if (i == 254) check8("w8_at_254", 254);
      if (i == 255) check8("w8_at_255", 255);
      if (i == 256) check8("w8_wrap", 0);
      if (i == 257) check8("w8_end", 1);
    end

    en = 1'b0;
    tick(); check8("final_clear", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
